// File: rtl/mult_sched_pkg.sv
// Shared definitions for mult_scheduler: FSM state encoding, default sizes
// and the round-robin pick helper.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 32;
    localparam int MAX_N_REQ = 16;

    // Nearest valid index after 'last' (wrapping); walking the offsets from far
    // to near lets the closest hit overwrite the others.
    function automatic logic [3:0] rr_next(input logic [15:0] valid,
                                           input logic [3:0]  last,
                                           input int          n_req);
        logic [3:0] pick;
        int         idx;
        pick = last;
        for (int k = MAX_N_REQ; k >= 1; k--) begin
            if (k <= n_req) begin
                idx = (int'(last) + k) % n_req;
                if (valid[4'(idx)]) begin
                    pick = 4'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Unsigned shift-add multiplier: the first iteration happens on the start
// edge, done pulses for one cycle once all WIDTH iterations have completed.
module seq_mult_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_done;

    logic [WIDTH-1:0] w_a_src;
    logic [WIDTH-1:0] w_hi_src;
    logic [WIDTH-1:0] w_lo_src;
    logic [WIDTH:0]   w_sum;

    assign w_a_src  = start ? a  : r_a;
    assign w_hi_src = start ? '0 : r_hi;
    assign w_lo_src = start ? b  : r_lo;
    assign w_sum    = {1'b0, w_hi_src} + (w_lo_src[0] ? {1'b0, w_a_src} : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start || r_run) begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], w_lo_src[WIDTH-1:1]};
                if (start) begin
                    r_a   <= a;
                    r_cnt <= CNT_W'(1);
                    r_run <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_run  <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign done = r_done;
    assign p    = {r_hi, r_lo};

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin arbiter sharing one sequential signed multiplier among N_REQ clients.
// Optional MULT_SCHED_ZERO_SKIP_EN: zero operands bypass the core straight to DONE.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    input  logic [N_REQ*WIDTH-1:0] req_y,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [2*WIDTH-1:0] rsp_z,
    output logic               busy
);
    sched_state_t      r_state;
    logic [ID_W-1:0]   r_last;
    logic [ID_W-1:0]   r_id;
    logic              r_neg;
    logic              r_rsp_valid;
    logic [2*WIDTH-1:0] r_rsp_z;
    logic              r_busy;

    logic [WIDTH-1:0]  w_x [N_REQ];
    logic [WIDTH-1:0]  w_y [N_REQ];
    logic [ID_W-1:0]   w_pick;
    logic              w_grant_en;
    logic              w_accept;
    logic              w_zero;
    logic              w_start;
    logic [WIDTH-1:0]  w_x_sel;
    logic [WIDTH-1:0]  w_y_sel;
    logic [WIDTH-1:0]  w_x_mag;
    logic [WIDTH-1:0]  w_y_mag;
    logic              w_core_done;
    logic [2*WIDTH-1:0] w_core_p;

    assign w_pick     = ID_W'(rr_next(16'(req_valid), 4'(r_last), N_REQ));
    assign w_grant_en = !rst && (r_state == ST_IDLE) && (|req_valid);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign w_x[gi]       = req_x[gi*WIDTH +: WIDTH];
        assign w_y[gi]       = req_y[gi*WIDTH +: WIDTH];
        assign req_ready[gi] = w_grant_en && (w_pick == ID_W'(gi));
    end

    assign w_accept = |(req_valid & req_ready);
    assign w_x_sel  = w_x[w_pick];
    assign w_y_sel  = w_y[w_pick];
    // Unsigned magnitude, so the most negative value maps to 2^(WIDTH-1).
    assign w_x_mag  = w_x_sel[WIDTH-1] ? -w_x_sel : w_x_sel;
    assign w_y_mag  = w_y_sel[WIDTH-1] ? -w_y_sel : w_y_sel;

`ifdef MULT_SCHED_ZERO_SKIP_EN
    assign w_zero = (w_x_sel == '0) || (w_y_sel == '0);
`else
    assign w_zero = 1'b0;
`endif
    assign w_start = w_accept && !w_zero;

    seq_mult_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .a     (w_x_mag),
        .b     (w_y_mag),
        .done  (w_core_done),
        .p     (w_core_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= ID_W'(N_REQ - 1);
            r_id        <= '0;
            r_neg       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_z     <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last <= w_pick;
                        r_id   <= w_pick;
                        r_neg  <= w_x_sel[WIDTH-1] ^ w_y_sel[WIDTH-1];
                        r_busy <= 1'b1;
                        if (w_zero) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_z     <= '0;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_core_done) begin
                        r_state     <= ST_DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_z     <= r_neg ? -w_core_p : w_core_p;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_z     = r_rsp_z;
    assign busy      = r_busy;

endmodule
